// File: rtl/radix4_booth_ctrl.sv
// Radix-4 Booth multiplier controller: sequences operand byte loads, ITER Booth
// iterations and a low-word/high-word result handshake for an external datapath.
module radix4_booth_ctrl #(
  parameter int ITER = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_in_valid,
  input  logic       i_out_ready,
  input  logic [2:0] i_sel_a,
  output logic       o_init_a,
  output logic       o_init_p,
  output logic       o_load_lsb_a,
  output logic       o_load_msb_a,
  output logic       o_load_lsb_b,
  output logic       o_load_msb_b,
  output logic       o_shift_a,
  output logic       o_load_partial,
  output logic [1:0] o_sel_mux,
  output logic       o_sel_add_sub,
  output logic       o_mux_sel,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_LD_A0  = 4'd2,
    S_LD_A1  = 4'd3,
    S_LD_B0  = 4'd4,
    S_LD_B1  = 4'd5,
    S_CALC   = 4'd6,
    S_OUT_LO = 4'd7,
    S_OUT_HI = 4'd8
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_idle;
  logic          r_init;
  logic          r_ld_a0;
  logic          r_ld_a1;
  logic          r_ld_b0;
  logic          r_ld_b1;
  logic          r_calc;
  logic          r_out_lo;
  logic          r_out_hi;
  logic [2:0]    w_booth;

  // Booth triplet -> {selMux[1:0], selAddSub}; selMux 00=2B, 01=0, 10=B.
  function automatic logic [2:0] booth_decode(input logic [2:0] trip);
    logic [2:0] res;
    case (trip)
      3'b000, 3'b111: res = 3'b010;
      3'b001, 3'b010: res = 3'b100;
      3'b011:         res = 3'b000;
      3'b100:         res = 3'b001;
      3'b101, 3'b110: res = 3'b101;
      default:        res = 3'b010;
    endcase
    return res;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_INIT;
        else         w_state_nxt = S_IDLE;
      end
      S_INIT: w_state_nxt = S_LD_A0;
      S_LD_A0: begin
        if (i_in_valid) w_state_nxt = S_LD_A1;
        else            w_state_nxt = S_LD_A0;
      end
      S_LD_A1: begin
        if (i_in_valid) w_state_nxt = S_LD_B0;
        else            w_state_nxt = S_LD_A1;
      end
      S_LD_B0: begin
        if (i_in_valid) w_state_nxt = S_LD_B1;
        else            w_state_nxt = S_LD_B0;
      end
      S_LD_B1: begin
        if (i_in_valid) begin
          w_state_nxt = S_CALC;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_LD_B1;
        end
      end
      S_CALC: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST) w_state_nxt = S_OUT_LO;
        else               w_state_nxt = S_CALC;
      end
      S_OUT_LO: begin
        if (i_out_ready) w_state_nxt = S_OUT_HI;
        else             w_state_nxt = S_OUT_LO;
      end
      S_OUT_HI: begin
        if (i_out_ready) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_OUT_HI;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, iteration counter and one-hot state flags registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_idle   <= 1'b1;
      r_init   <= 1'b0;
      r_ld_a0  <= 1'b0;
      r_ld_a1  <= 1'b0;
      r_ld_b0  <= 1'b0;
      r_ld_b1  <= 1'b0;
      r_calc   <= 1'b0;
      r_out_lo <= 1'b0;
      r_out_hi <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idle   <= (w_state_nxt == S_IDLE);
      r_init   <= (w_state_nxt == S_INIT);
      r_ld_a0  <= (w_state_nxt == S_LD_A0);
      r_ld_a1  <= (w_state_nxt == S_LD_A1);
      r_ld_b0  <= (w_state_nxt == S_LD_B0);
      r_ld_b1  <= (w_state_nxt == S_LD_B1);
      r_calc   <= (w_state_nxt == S_CALC);
      r_out_lo <= (w_state_nxt == S_OUT_LO);
      r_out_hi <= (w_state_nxt == S_OUT_HI);
    end
  end

  assign w_booth = booth_decode(i_sel_a);

  // Outside CALC the adder must pass P through unchanged, whatever selA shows.
  always_comb begin
    o_sel_mux     = 2'b01;
    o_sel_add_sub = 1'b0;
    if (r_calc) begin
      o_sel_mux     = w_booth[2:1];
      o_sel_add_sub = w_booth[0];
    end else begin
      o_sel_mux     = 2'b01;
      o_sel_add_sub = 1'b0;
    end
  end

  assign o_init_a       = r_init;
  assign o_init_p       = r_init;
  assign o_load_lsb_a   = r_ld_a0 & i_in_valid;
  assign o_load_msb_a   = r_ld_a1 & i_in_valid;
  assign o_load_lsb_b   = r_ld_b0 & i_in_valid;
  assign o_load_msb_b   = r_ld_b1 & i_in_valid;
  assign o_shift_a      = r_calc;
  assign o_load_partial = r_calc;
  assign o_mux_sel      = r_out_lo;
  assign o_in_ready     = r_ld_a0 | r_ld_a1 | r_ld_b0 | r_ld_b1;
  assign o_out_valid    = r_out_lo | r_out_hi;
  assign o_busy         = ~r_idle;
  assign o_done         = r_out_hi & i_out_ready;

endmodule
